// File: rtl/ifetch_tag_multi_if.sv
// Bundle of all ifetch tag stage signals except clock and reset.
// The slave modport is the tag stage's view; master is the driving side.
interface ifetch_tag_multi_if #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 64,
  parameter int LINE_BYTES  = 64
);
  localparam int OFS_W = $clog2(LINE_BYTES);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - SET_W - OFS_W;
  localparam int TID_W = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0]    ts_fetch_en;
  logic                      ifd_stall;
  logic                      ifd_cache_miss;
  logic                      ifd_near_miss;
  logic [TID_W-1:0]          ifd_cache_miss_thread_idx;
  logic [NUM_WAYS-1:0]       l2i_itag_update_en_oh;
  logic [SET_W-1:0]          l2i_itag_update_set;
  logic [TAG_W-1:0]          l2i_itag_update_tag;
  logic                      l2i_itag_update_valid;
  logic [NUM_THREADS-1:0]    l2i_icache_wake_bitmap;
  logic                      wb_rollback_en;
  logic [TID_W-1:0]          wb_rollback_thread_idx;
  logic [31:0]               wb_rollback_pc;
  logic                      inv_all_en;
  logic                      ift_instruction_requested;
  logic [31:0]               ift_pc;
  logic [TID_W-1:0]          ift_thread_idx;
  logic [NUM_WAYS*TAG_W-1:0] ift_tag;
  logic [NUM_WAYS-1:0]       ift_valid;
  logic [NUM_THREADS-1:0]    ift_wait_threads;

  modport slave (
    input  ts_fetch_en, ifd_stall, ifd_cache_miss, ifd_near_miss,
           ifd_cache_miss_thread_idx, l2i_itag_update_en_oh,
           l2i_itag_update_set, l2i_itag_update_tag, l2i_itag_update_valid,
           l2i_icache_wake_bitmap, wb_rollback_en, wb_rollback_thread_idx,
           wb_rollback_pc, inv_all_en,
    output ift_instruction_requested, ift_pc, ift_thread_idx, ift_tag,
           ift_valid, ift_wait_threads
  );

  modport master (
    output ts_fetch_en, ifd_stall, ifd_cache_miss, ifd_near_miss,
           ifd_cache_miss_thread_idx, l2i_itag_update_en_oh,
           l2i_itag_update_set, l2i_itag_update_tag, l2i_itag_update_valid,
           l2i_icache_wake_bitmap, wb_rollback_en, wb_rollback_thread_idx,
           wb_rollback_pc, inv_all_en,
    input  ift_instruction_requested, ift_pc, ift_thread_idx, ift_tag,
           ift_valid, ift_wait_threads
  );
endinterface

// File: rtl/ifetch_tag_multi.sv
// Instruction-fetch tag stage: round-robin thread pick, L1I tag/valid lookup, registered result.
// Define IFETCH_INVALIDATE_ALL_EN to make inv_all_en clear every valid bit.
module ifetch_tag_multi #(
  parameter int          NUM_THREADS = 4,
  parameter int          NUM_WAYS    = 4,
  parameter int          NUM_SETS    = 64,
  parameter int          LINE_BYTES  = 64,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input logic               clk,
  input logic               reset,
  ifetch_tag_multi_if.slave bus
);
  localparam int OFS_W = $clog2(LINE_BYTES);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - SET_W - OFS_W;
  localparam int TID_W = $clog2(NUM_THREADS);

  logic [31:0]            pc_q [NUM_THREADS];
  logic [31:0]            pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] wait_q, wait_d;
  logic [TID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   last_vld_q, last_vld_d;

  logic                   req_q, req_d;
  logic [31:0]            pc_out_q, pc_out_d;
  logic [TID_W-1:0]       tid_q, tid_d;
  logic [NUM_WAYS-1:0]    valid_out_q;

  logic [NUM_THREADS-1:0] eligible;
  logic                   any_eligible;
  logic                   grant_vld;
  logic [TID_W-1:0]       grant_idx;
  logic [TID_W-1:0]       arb_cand;
  logic                   arb_found;
  logic                   miss_any;
  logic                   cancel;
  logic [NUM_THREADS-1:0] miss_oh;
  logic [31:0]            lookup_pc;
  logic [SET_W-1:0]       lookup_set;
  logic [NUM_WAYS-1:0]    valid_lookup;
  logic [NUM_WAYS-1:0][TAG_W-1:0] tag_rd;
  logic                   inv_now;

`ifdef IFETCH_INVALIDATE_ALL_EN
  assign inv_now = bus.inv_all_en;
`else
  logic unused_inv;
  assign inv_now    = 1'b0;
  assign unused_inv = bus.inv_all_en;
`endif

  assign eligible     = bus.ts_fetch_en & ~wait_q;
  assign any_eligible = |eligible;
  assign grant_vld    = any_eligible & ~bus.ifd_stall;
  assign miss_any     = bus.ifd_cache_miss | bus.ifd_near_miss;

  // First eligible thread at or after the rotating priority pointer
  always_comb begin
    grant_idx = '0;
    arb_cand  = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      arb_cand = rr_ptr_q + TID_W'(k);
      if (!arb_found && eligible[arb_cand]) begin
        grant_idx = arb_cand;
        arb_found = 1'b1;
      end
    end
  end

  assign cancel = (miss_any && bus.ifd_cache_miss_thread_idx == grant_idx) ||
                  (bus.wb_rollback_en && bus.wb_rollback_thread_idx == grant_idx);

  // A stall replays the held lookup so late tag writes still show up
  always_comb begin
    req_d      = any_eligible && !cancel;
    pc_out_d   = pc_q[grant_idx];
    tid_d      = grant_idx;
    rr_ptr_d   = rr_ptr_q;
    last_vld_d = any_eligible;
    if (bus.ifd_stall) begin
      req_d      = req_q;
      pc_out_d   = pc_out_q;
      tid_d      = tid_q;
      last_vld_d = last_vld_q;
    end else if (any_eligible) begin
      rr_ptr_d = grant_idx + TID_W'(1);
    end
  end

  assign lookup_pc  = pc_out_d;
  assign lookup_set = lookup_pc[OFS_W +: SET_W];

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      pc_d[t] = pc_q[t];
      if (bus.wb_rollback_en && bus.wb_rollback_thread_idx == TID_W'(t))
        pc_d[t] = bus.wb_rollback_pc;
      else if (miss_any && last_vld_q && tid_q == TID_W'(t))
        pc_d[t] = pc_q[t] - 32'd4;
      else if (grant_vld && grant_idx == TID_W'(t))
        pc_d[t] = pc_q[t] + 32'd4;
    end
  end

  assign miss_oh = bus.ifd_cache_miss ? (NUM_THREADS'(1) << bus.ifd_cache_miss_thread_idx)
                                      : '0;
  assign wait_d  = (wait_q | miss_oh) & ~bus.l2i_icache_wake_bitmap;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_PC;
      wait_q      <= '0;
      rr_ptr_q    <= '0;
      last_vld_q  <= 1'b0;
      req_q       <= 1'b0;
      pc_out_q    <= '0;
      tid_q       <= '0;
      valid_out_q <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= pc_d[t];
      wait_q      <= wait_d;
      rr_ptr_q    <= rr_ptr_d;
      last_vld_q  <= last_vld_d;
      req_q       <= req_d;
      pc_out_q    <= pc_out_d;
      tid_q       <= tid_d;
      valid_out_q <= valid_lookup;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]    tag_mem [NUM_SETS];
      logic [TAG_W-1:0]    tag_rd_q;
      logic [NUM_SETS-1:0] vld_q;
      logic                wr_en;
      logic                wr_hit;

      assign wr_en  = bus.l2i_itag_update_en_oh[gi];
      assign wr_hit = wr_en && (bus.l2i_itag_update_set == lookup_set);

      always_ff @(posedge clk) begin
        if (wr_en) tag_mem[bus.l2i_itag_update_set] <= bus.l2i_itag_update_tag;
      end

      // Registered read; a same-address write forwards the new tag
      always_ff @(posedge clk) begin
        if (reset)       tag_rd_q <= '0;
        else if (wr_hit) tag_rd_q <= bus.l2i_itag_update_tag;
        else             tag_rd_q <= tag_mem[lookup_set];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= '0;
        end else begin
          if (inv_now) vld_q <= '0;
          if (wr_en) vld_q[bus.l2i_itag_update_set] <= bus.l2i_itag_update_valid;
        end
      end

      assign valid_lookup[gi] = wr_hit  ? bus.l2i_itag_update_valid :
                                inv_now ? 1'b0 : vld_q[lookup_set];
      assign tag_rd[gi] = tag_rd_q;
    end
  endgenerate

  assign bus.ift_instruction_requested = req_q;
  assign bus.ift_pc                    = pc_out_q;
  assign bus.ift_thread_idx            = tid_q;
  assign bus.ift_tag                   = tag_rd;
  assign bus.ift_valid                 = valid_out_q;
  assign bus.ift_wait_threads          = wait_q;
endmodule

// File: tb/tb_ifetch_tag_multi.sv
// Randomized bench for ifetch_tag_multi against a cycle-level reference model.
module tb_ifetch_tag_multi;
  localparam int T = 4, W = 4, S = 64, LB = 64;
  localparam int TAG_W = 20, TID_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_tag_multi_if #(.NUM_THREADS(T), .NUM_WAYS(W), .NUM_SETS(S), .LINE_BYTES(LB)) bus ();

  ifetch_tag_multi #(.NUM_THREADS(T), .NUM_WAYS(W), .NUM_SETS(S), .LINE_BYTES(LB),
                     .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0]      m_pc [T];
  logic [T-1:0]     m_wait;
  int               m_ptr;
  int               m_last;
  bit               m_last_v;
  bit               m_valid [W][S];
  logic [TAG_W-1:0] m_tag [W][S];
  bit               m_known [W][S];
  bit               e_req;
  logic [31:0]      e_pc;
  int               e_tid;
  logic [W-1:0]     e_valid;
  logic [TAG_W-1:0] e_tag [W];
  bit               e_tag_known [W];

  task automatic drive_idle();
    bus.ts_fetch_en = '0; bus.ifd_stall = 0; bus.ifd_cache_miss = 0; bus.ifd_near_miss = 0;
    bus.ifd_cache_miss_thread_idx = '0; bus.l2i_itag_update_en_oh = '0;
    bus.l2i_itag_update_set = '0; bus.l2i_itag_update_tag = '0; bus.l2i_itag_update_valid = 0;
    bus.l2i_icache_wake_bitmap = '0; bus.wb_rollback_en = 0; bus.wb_rollback_thread_idx = '0;
    bus.wb_rollback_pc = '0; bus.inv_all_en = 0;
  endtask

  task automatic model_reset();
    for (int t = 0; t < T; t++) m_pc[t] = 32'h0;
    m_wait = '0; m_ptr = 0; m_last = 0; m_last_v = 0;
    for (int w = 0; w < W; w++) for (int s = 0; s < S; s++) m_valid[w][s] = 0;
    e_req = 0; e_pc = 0; e_tid = 0; e_valid = '0;
  endtask

  task automatic do_reset(input bit noisy);
    reset = 1'b1;
    drive_idle();
    if (noisy) begin
      bus.l2i_icache_wake_bitmap = 4'b1111; bus.ts_fetch_en = 4'b1111;
      bus.ifd_cache_miss = 1; bus.ifd_cache_miss_thread_idx = 2'd1;
    end
    @(negedge clk); @(negedge clk);
    check("rst_req",   bus.ift_instruction_requested, 0);
    check("rst_pc",    bus.ift_pc, 0);
    check("rst_tid",   bus.ift_thread_idx, 0);
    check("rst_tag",   bus.ift_tag, 0);
    check("rst_valid", bus.ift_valid, 0);
    check("rst_wait",  bus.ift_wait_threads, 0);
    model_reset();
    reset = 1'b0;
    drive_idle();
  endtask

  // Applies the rules to the inputs currently driven; outputs land next cycle
  task automatic model_update();
    logic [T-1:0] elig;
    bit has_elig, found, stall, miss_any, n_req, hit, inv_eff;
    int g, midx, rbidx, ltid, set, t;
    logic [31:0] lpc;
    elig = bus.ts_fetch_en & ~m_wait;
    has_elig = |elig; found = 0; g = 0;
    stall = bus.ifd_stall;
    miss_any = bus.ifd_cache_miss | bus.ifd_near_miss;
    midx = int'(bus.ifd_cache_miss_thread_idx);
    rbidx = int'(bus.wb_rollback_thread_idx);
`ifdef IFETCH_INVALIDATE_ALL_EN
    inv_eff = bus.inv_all_en;
`else
    inv_eff = 0;
`endif
    for (int k = 0; k < T; k++) begin
      t = (m_ptr + k) % T;
      if (!found && elig[t]) begin g = t; found = 1; end
    end
    if (stall) begin
      n_req = e_req; lpc = e_pc; ltid = e_tid;
    end else begin
      n_req = has_elig && !(miss_any && midx == g) && !(bus.wb_rollback_en && rbidx == g);
      lpc = m_pc[g]; ltid = g;
    end
    set = int'(lpc[11:6]);
    for (int w = 0; w < W; w++) begin
      hit = bus.l2i_itag_update_en_oh[w] && int'(bus.l2i_itag_update_set) == set;
      e_valid[w] = hit ? bus.l2i_itag_update_valid : (inv_eff ? 1'b0 : m_valid[w][set]);
      e_tag[w] = hit ? bus.l2i_itag_update_tag : m_tag[w][set];
      e_tag_known[w] = hit ? 1'b1 : m_known[w][set];
    end
    for (int i = 0; i < T; i++) begin
      if (bus.wb_rollback_en && rbidx == i) m_pc[i] = bus.wb_rollback_pc;
      else if (miss_any && m_last_v && m_last == i) m_pc[i] = m_pc[i] - 4;
      else if (!stall && has_elig && g == i) m_pc[i] = m_pc[i] + 4;
    end
    if (!stall) begin
      m_last_v = has_elig; m_last = g;
      if (has_elig) m_ptr = (g + 1) % T;
    end
    if (bus.ifd_cache_miss) m_wait[midx] = 1'b1;
    m_wait = m_wait & ~bus.l2i_icache_wake_bitmap;
    if (inv_eff) for (int w = 0; w < W; w++) for (int s = 0; s < S; s++) m_valid[w][s] = 0;
    for (int w = 0; w < W; w++)
      if (bus.l2i_itag_update_en_oh[w]) begin
        m_valid[w][bus.l2i_itag_update_set] = bus.l2i_itag_update_valid;
        m_tag[w][bus.l2i_itag_update_set]   = bus.l2i_itag_update_tag;
        m_known[w][bus.l2i_itag_update_set] = 1'b1;
      end
    e_req = n_req; e_pc = lpc; e_tid = ltid;
  endtask

  task automatic check_outputs();
    check("req",  bus.ift_instruction_requested, e_req);
    check("wait", bus.ift_wait_threads, m_wait);
    if (e_req) begin
      check("pc",    bus.ift_pc, e_pc);
      check("tid",   bus.ift_thread_idx, e_tid);
      check("valid", bus.ift_valid, e_valid);
      for (int w = 0; w < W; w++)
        if (e_tag_known[w]) check($sformatf("tag%0d", w), bus.ift_tag[w*TAG_W +: TAG_W], e_tag[w]);
    end
  endtask

  task automatic cycle();
    model_update();
    @(negedge clk);
    check_outputs();
    $display("[TB] cyc req=%0d tid=%0d pc=%08h valid=%b wait=%b",
             bus.ift_instruction_requested, bus.ift_thread_idx, bus.ift_pc,
             bus.ift_valid, bus.ift_wait_threads);
  endtask

  task automatic drive_random();
    int w;
    drive_idle();
    bus.ifd_stall   = ($urandom % 8 == 0);
    bus.ts_fetch_en = ($urandom % 2 == 0) ? 4'b1111 : 4'($urandom);
    if (!bus.ifd_stall && e_req && $urandom % 6 == 0) begin
      if ($urandom % 3 == 0) bus.ifd_near_miss = 1; else bus.ifd_cache_miss = 1;
      bus.ifd_cache_miss_thread_idx = 2'(e_tid);
    end
    if (!bus.ifd_stall && $urandom % 12 == 0) begin
      bus.wb_rollback_en = 1;
      bus.wb_rollback_thread_idx = 2'($urandom);
      bus.wb_rollback_pc = {22'h0, 8'($urandom), 2'b00};
    end
    if ($urandom % 3 == 0) begin
      w = int'($urandom_range(0, W - 1));
      bus.l2i_itag_update_en_oh = 4'(1 << w);
      bus.l2i_itag_update_set   = ($urandom % 2 == 0) ? m_pc[$urandom % T][11:6] : 6'($urandom);
      bus.l2i_itag_update_tag   = 20'($urandom);
      bus.l2i_itag_update_valid = ($urandom % 4 != 0);
    end
    if ($urandom % 8 == 0) bus.l2i_icache_wake_bitmap = 4'($urandom);
    bus.inv_all_en = ($urandom % 64 == 0);
  endtask

  initial begin
    for (int w = 0; w < W; w++) for (int s = 0; s < S; s++) begin
      m_known[w][s] = 0; m_tag[w][s] = '0;
    end
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    do_reset(1'b0);
    // All threads fetching, no fills: round-robin from thread 0
    for (int i = 0; i < 9; i++) begin
      drive_idle();
      bus.ts_fetch_en = 4'b1111;
      cycle();
    end
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(1'b1);
      drive_random();
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
